// File: rtl/riscv_csr_pkg.sv
// Shared CSR-side constants and types for the single-level M-mode trap path.
// Interrupt line k reports cause IRQ_CAUSE_BASE+k with the interrupt bit set.
package riscv_csr_pkg;

  localparam int MXLEN = 32;

  localparam logic [MXLEN-1:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [MXLEN-1:0] CAUSE_BREAK   = 32'd3;
  localparam logic [MXLEN-1:0] CAUSE_ECALL_M = 32'd11;
  localparam int               IRQ_CAUSE_BASE = 16;
  localparam int               MCAUSE_INT_BIT = MXLEN - 1;
  localparam logic [1:0]       MTVEC_MODE_VEC = 2'b01;

  typedef enum logic [2:0] {
    TS_IDLE,
    TS_TRAP,
    TS_HANDLER,
    TS_RET,
    TS_LOCKUP
  } trap_state_e;

  function automatic logic [MXLEN-1:0] irq_cause(input logic [3:0] idx);
    logic [MXLEN-1:0] c;
    c = MXLEN'(IRQ_CAUSE_BASE) + MXLEN'(idx);
    c[MCAUSE_INT_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/riscv_irq_prio.sv
// Combinational fixed-priority picker over enabled pending interrupt lines.
// The lowest-numbered eligible line wins.
module riscv_irq_prio #(
  parameter int IRQ_NUM = 16
) (
  input  logic [IRQ_NUM-1:0] pending_i,
  input  logic [IRQ_NUM-1:0] enable_i,
  output logic               valid_o,
  output logic [3:0]         index_o,
  output logic [IRQ_NUM-1:0] onehot_o
);

  logic [IRQ_NUM-1:0] eligible;

  assign eligible = pending_i & enable_i;

  // Scan from the top so the last hit, the lowest index, is what remains.
  always_comb begin
    valid_o  = 1'b0;
    index_o  = '0;
    onehot_o = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        valid_o     = 1'b1;
        index_o     = 4'(k);
        onehot_o    = '0;
        onehot_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Trap/interrupt controller for a single-level M-mode core: decides traps,
// feeds the CSR file's trap side and redirects fetch to the handler and back.
module riscv_trap_ctrl
  import riscv_csr_pkg::*;
#(
  parameter int IRQ_NUM = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic               instr_valid_i,
  input  logic [MXLEN-1:0]   pc_i,
  input  logic               illegal_i,
  input  logic               ebreak_i,
  input  logic               ecall_i,
  input  logic               mret_i,
  input  logic [MXLEN-1:0]   mie_i,
  input  logic [MXLEN-1:0]   mtvec_i,
  input  logic [MXLEN-1:0]   mepc_i,
  output logic               flush_o,
  output logic               trap_o,
  output logic [MXLEN-1:0]   mcause_o,
  output logic [MXLEN-1:0]   trap_pc_o,
  output logic               redirect_o,
  output logic [MXLEN-1:0]   redirect_pc_o,
  output logic [IRQ_NUM-1:0] irq_ack_o,
  output logic               in_handler_o,
  output logic               lockup_o
);

  trap_state_e        state_q, state_d;
  logic [IRQ_NUM-1:0] pending_q, pending_d, irq_prev_q, ack_q, ack_d;
  logic [MXLEN-1:0]   cause_q, cause_d, tpc_q, tpc_d;
  logic               prio_valid;
  logic [3:0]         prio_idx;
  logic [IRQ_NUM-1:0] prio_onehot;
  logic               exc_valid, take_exc, take_irq, take;
  logic               handler_fault, handler_mret;
  logic [MXLEN-1:0]   vec_base, vec_off;
  logic               unused_mie;

  assign unused_mie = ^mie_i[IRQ_CAUSE_BASE-1:0];

  riscv_irq_prio #(.IRQ_NUM(IRQ_NUM)) u_prio (
    .pending_i (pending_q),
    .enable_i  (mie_i[IRQ_CAUSE_BASE +: IRQ_NUM]),
    .valid_o   (prio_valid),
    .index_o   (prio_idx),
    .onehot_o  (prio_onehot)
  );

  assign exc_valid     = instr_valid_i & (illegal_i | ebreak_i | ecall_i);
  assign take_exc      = (state_q == TS_IDLE) & instr_valid_i
                         & (illegal_i | ebreak_i | ecall_i | mret_i);
  assign take_irq      = (state_q == TS_IDLE) & instr_valid_i & prio_valid & ~take_exc;
  assign take          = take_exc | take_irq;
  assign handler_fault = (state_q == TS_HANDLER) & exc_valid;
  assign handler_mret  = (state_q == TS_HANDLER) & instr_valid_i & mret_i & ~exc_valid;

  // A new rising edge on a line being acknowledged survives the ack.
  assign pending_d = (pending_q & ~irq_ack_o) | (irq_i & ~irq_prev_q);

  always_comb begin
    cause_d = cause_q;
    tpc_d   = tpc_q;
    ack_d   = ack_q;
    if (take) begin
      tpc_d = pc_i;
      ack_d = '0;
      if (illegal_i)     cause_d = CAUSE_ILLEGAL;
      else if (ebreak_i) cause_d = CAUSE_BREAK;
      else if (ecall_i)  cause_d = CAUSE_ECALL_M;
      else if (mret_i)   cause_d = CAUSE_ILLEGAL;
      else begin
        cause_d = irq_cause(prio_idx);
        ack_d   = prio_onehot;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pending_q  <= '0;
      irq_prev_q <= '0;
      ack_q      <= '0;
      cause_q    <= '0;
      tpc_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= irq_i;
      ack_q      <= ack_d;
      cause_q    <= cause_d;
      tpc_q      <= tpc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= TS_IDLE;
    else         state_q <= state_d;
  end

  // A fault while the handler runs is a double fault and wins over MRET.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TS_IDLE:    if (take) state_d = TS_TRAP;
      TS_TRAP:    state_d = TS_HANDLER;
      TS_HANDLER: begin
        if (handler_fault)     state_d = TS_LOCKUP;
        else if (handler_mret) state_d = TS_RET;
      end
      TS_RET:     state_d = TS_IDLE;
      TS_LOCKUP:  state_d = TS_LOCKUP;
      default:    state_d = TS_IDLE;
    endcase
  end

  assign vec_base = {mtvec_i[MXLEN-1:2], 2'b00};
  assign vec_off  = {cause_q[MXLEN-3:0], 2'b00};

  always_comb begin
    flush_o       = 1'b0;
    trap_o        = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    irq_ack_o     = '0;
    in_handler_o  = 1'b0;
    lockup_o      = 1'b0;
    case (state_q)
      TS_IDLE: flush_o = take;
      TS_TRAP: begin
        trap_o        = 1'b1;
        redirect_o    = 1'b1;
        irq_ack_o     = ack_q;
        redirect_pc_o = vec_base;
        if ((mtvec_i[1:0] == MTVEC_MODE_VEC) && cause_q[MCAUSE_INT_BIT])
          redirect_pc_o = vec_base + vec_off;
      end
      TS_HANDLER: begin
        in_handler_o = 1'b1;
        flush_o      = handler_fault | handler_mret;
      end
      TS_RET: begin
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_i;
      end
      TS_LOCKUP: begin
        lockup_o = 1'b1;
        flush_o  = instr_valid_i;
      end
      default: ;
    endcase
  end

  assign mcause_o  = cause_q;
  assign trap_pc_o = tpc_q;

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Self-checking bench for riscv_trap_ctrl: per-cycle vectors of inputs and
// expected outputs, queued as expectations when driven and checked mid-cycle.
module tb_riscv_trap_ctrl;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] ME = 32'h002E_0000;
  localparam logic [31:0] MF = 32'h003E_0000;
  localparam logic [31:0] T0 = 32'h0000_0100;
  localparam logic [31:0] TV = 32'h0000_0101;

  typedef struct {
    logic        rstn;
    logic [15:0] irq;
    logic        valid;
    logic [31:0] pc;
    logic        ill, ebr, ecl, mret;
    logic [31:0] mie, mtvec, mepc;
    logic        flush, trap;
    logic [31:0] cause, tpc;
    logic        redir;
    logic [31:0] rpc;
    logic [15:0] ack;
    logic        inh, lock;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] irq;
  logic        instrValid, illegal, ebreak, ecall, mret;
  logic [31:0] pc, mie, mtvec, mepc;
  logic        flush_o, trap_o, redirect_o, in_handler_o, lockup_o;
  logic [31:0] mcause_o, trap_pc_o, redirect_pc_o;
  logic [15:0] irq_ack_o;

  vec_t tbl[$];
  vec_t expQ[$];
  int   vectorsApplied = 0;
  int   miscompares = 0;

  riscv_trap_ctrl #(.IRQ_NUM(16)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .irq_i         (irq),
    .instr_valid_i (instrValid),
    .pc_i          (pc),
    .illegal_i     (illegal),
    .ebreak_i      (ebreak),
    .ecall_i       (ecall),
    .mret_i        (mret),
    .mie_i         (mie),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .flush_o       (flush_o),
    .trap_o        (trap_o),
    .mcause_o      (mcause_o),
    .trap_pc_o     (trap_pc_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .irq_ack_o     (irq_ack_o),
    .in_handler_o  (in_handler_o),
    .lockup_o      (lockup_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs and queue what the DUT must show in that cycle.
  task automatic applyStimulus(input vec_t v);
    rstn       = v.rstn;
    irq        = v.irq;
    instrValid = v.valid;
    pc         = v.pc;
    illegal    = v.ill;
    ebreak     = v.ebr;
    ecall      = v.ecl;
    mret       = v.mret;
    mie        = v.mie;
    mtvec      = v.mtvec;
    mepc       = v.mepc;
    expQ.push_back(v);
  endtask

  // Redirect target is only meaningful while the redirect strobe is expected.
  task automatic checkOutput();
    vec_t e;
    logic bad;
    vectorsApplied++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: no expectation queued, act flush=%b trap=%b", flush_o, trap_o);
      return;
    end
    e = expQ.pop_front();
    bad = (flush_o !== e.flush) || (trap_o !== e.trap) || (mcause_o !== e.cause) ||
          (trap_pc_o !== e.tpc) || (redirect_o !== e.redir) || (irq_ack_o !== e.ack) ||
          (in_handler_o !== e.inh) || (lockup_o !== e.lock) ||
          (e.redir && (redirect_pc_o !== e.rpc));
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL vec%0d: act flush=%b trap=%b cause=%h tpc=%h redir=%b rpc=%h ack=%h inh=%b lock=%b | exp flush=%b trap=%b cause=%h tpc=%h redir=%b rpc=%h ack=%h inh=%b lock=%b",
               vectorsApplied - 1, flush_o, trap_o, mcause_o, trap_pc_o, redirect_o, redirect_pc_o,
               irq_ack_o, in_handler_o, lockup_o, e.flush, e.trap, e.cause, e.tpc, e.redir, e.rpc,
               e.ack, e.inh, e.lock);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors applied", vectorsApplied);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0; irq = '0; instrValid = 1'b0; pc = '0;
    illegal = 1'b0; ebreak = 1'b0; ecall = 1'b0; mret = 1'b0;
    mie = ME; mtvec = T0; mepc = '0;

    //            rstn irq     vld pc      il eb ec mr mie mtvec mepc      fl tr cause          tpc       rd rpc       ack      inh lk
    // Line 3 interrupt, direct mode, then MRET.
    tbl.push_back(vec_t'{Y, 16'h0000, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, N, 32'h0, 32'h00, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, N, 32'h0, 32'h00, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, Y, 32'h40, N, N, N, N, ME, T0, 32'h00, Y, N, 32'h0, 32'h00, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h40, N, N, N, N, ME, T0, 32'h00, N, Y, 32'h8000_0013, 32'h40, Y, 32'h100, 16'h0008, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, N, 32'h8000_0013, 32'h40, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0008, Y, 32'h100, N, N, N, Y, ME, T0, 32'h40, Y, N, 32'h8000_0013, 32'h40, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, T0, 32'h40, N, N, 32'h8000_0013, 32'h40, Y, 32'h40, 16'h0, N, N});
    // Vectored mode: interrupt offset applied, ecall goes to base.
    tbl.push_back(vec_t'{Y, 16'h0000, N, 32'h00, N, N, N, N, ME, TV, 32'h00, N, N, 32'h8000_0013, 32'h40, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, TV, 32'h00, N, N, 32'h8000_0013, 32'h40, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, Y, 32'h80, N, N, N, N, ME, TV, 32'h00, Y, N, 32'h8000_0013, 32'h40, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, TV, 32'h00, N, Y, 32'h8000_0013, 32'h80, Y, 32'h14C, 16'h0008, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, Y, 32'h14C, N, N, N, Y, ME, TV, 32'h80, Y, N, 32'h8000_0013, 32'h80, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, TV, 32'h80, N, N, 32'h8000_0013, 32'h80, Y, 32'h80, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, Y, 32'h84, N, N, Y, N, ME, TV, 32'h00, Y, N, 32'h8000_0013, 32'h80, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, TV, 32'h00, N, Y, 32'h0000_000B, 32'h84, Y, 32'h100, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0008, Y, 32'h100, N, N, N, Y, ME, TV, 32'h88, Y, N, 32'h0000_000B, 32'h84, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, ME, TV, 32'h88, N, N, 32'h0000_000B, 32'h84, Y, 32'h88, 16'h0, N, N});
    // Lines 5 and 2 rise together: 2 first, 5 after MRET; 5 not taken inside handler.
    tbl.push_back(vec_t'{Y, 16'h0024, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, N, 32'h0000_000B, 32'h84, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0024, Y, 32'h44, N, N, N, N, ME, T0, 32'h00, Y, N, 32'h0000_000B, 32'h84, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0024, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, Y, 32'h8000_0012, 32'h44, Y, 32'h100, 16'h0004, N, N});
    tbl.push_back(vec_t'{Y, 16'h0024, Y, 32'h100, N, N, N, N, ME, T0, 32'h00, N, N, 32'h8000_0012, 32'h44, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0024, Y, 32'h104, N, N, N, Y, ME, T0, 32'h44, Y, N, 32'h8000_0012, 32'h44, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0024, N, 32'h00, N, N, N, N, ME, T0, 32'h44, N, N, 32'h8000_0012, 32'h44, Y, 32'h44, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0024, Y, 32'h44, N, N, N, N, ME, T0, 32'h00, Y, N, 32'h8000_0012, 32'h44, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0024, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, Y, 32'h8000_0015, 32'h44, Y, 32'h100, 16'h0020, N, N});
    // Line 1 rises in the handler; held until the first valid IDLE cycle.
    tbl.push_back(vec_t'{Y, 16'h0026, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, N, 32'h8000_0015, 32'h44, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0026, Y, 32'h104, N, N, N, N, ME, T0, 32'h00, N, N, 32'h8000_0015, 32'h44, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0026, Y, 32'h108, N, N, N, Y, ME, T0, 32'h48, Y, N, 32'h8000_0015, 32'h44, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0026, N, 32'h00, N, N, N, N, ME, T0, 32'h48, N, N, 32'h8000_0015, 32'h44, Y, 32'h48, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0026, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, N, 32'h8000_0015, 32'h44, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0026, Y, 32'h48, N, N, N, N, ME, T0, 32'h00, Y, N, 32'h8000_0015, 32'h44, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0026, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, Y, 32'h8000_0011, 32'h48, Y, 32'h100, 16'h0002, N, N});
    tbl.push_back(vec_t'{Y, 16'h0026, Y, 32'h100, N, N, N, Y, ME, T0, 32'h4C, Y, N, 32'h8000_0011, 32'h48, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0026, N, 32'h00, N, N, N, N, ME, T0, 32'h4C, N, N, 32'h8000_0011, 32'h48, Y, 32'h4C, 16'h0, N, N});
    // Line 4 pending while disabled, traps once its enable is set.
    tbl.push_back(vec_t'{Y, 16'h0036, N, 32'h00, N, N, N, N, ME, T0, 32'h00, N, N, 32'h8000_0011, 32'h48, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0036, Y, 32'h50, N, N, N, N, ME, T0, 32'h00, N, N, 32'h8000_0011, 32'h48, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0036, Y, 32'h50, N, N, N, N, MF, T0, 32'h00, Y, N, 32'h8000_0011, 32'h48, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h0036, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, Y, 32'h8000_0014, 32'h50, Y, 32'h100, 16'h0010, N, N});
    tbl.push_back(vec_t'{Y, 16'h0036, Y, 32'h100, N, N, N, Y, MF, T0, 32'h50, Y, N, 32'h8000_0014, 32'h50, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h0036, N, 32'h00, N, N, N, N, MF, T0, 32'h50, N, N, 32'h8000_0014, 32'h50, Y, 32'h50, 16'h0, N, N});
    // Illegal beats a pending enabled irq, which then stays pending.
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, N, 32'h8000_0014, 32'h50, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h60, Y, N, N, N, MF, T0, 32'h00, Y, N, 32'h8000_0014, 32'h50, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, Y, 32'h0000_0002, 32'h60, Y, 32'h100, 16'h0000, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h100, N, N, N, Y, MF, T0, 32'h60, Y, N, 32'h0000_0002, 32'h60, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, T0, 32'h60, N, N, 32'h0000_0002, 32'h60, Y, 32'h60, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h60, N, N, N, N, MF, T0, 32'h00, Y, N, 32'h0000_0002, 32'h60, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, Y, 32'h8000_0013, 32'h60, Y, 32'h100, 16'h0008, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h100, N, N, N, Y, MF, T0, 32'h64, Y, N, 32'h8000_0013, 32'h60, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, T0, 32'h64, N, N, 32'h8000_0013, 32'h60, Y, 32'h64, 16'h0, N, N});
    // MRET outside the handler is illegal; EBREAK in vectored mode goes to base.
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h70, N, N, N, Y, MF, T0, 32'h00, Y, N, 32'h8000_0013, 32'h60, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, Y, 32'h0000_0002, 32'h70, Y, 32'h100, 16'h0000, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h100, N, N, N, Y, MF, T0, 32'h74, Y, N, 32'h0000_0002, 32'h70, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, T0, 32'h74, N, N, 32'h0000_0002, 32'h70, Y, 32'h74, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h78, N, Y, N, N, MF, TV, 32'h00, Y, N, 32'h0000_0002, 32'h70, N, 32'h0, 16'h0, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, TV, 32'h00, N, Y, 32'h0000_0003, 32'h78, Y, 32'h100, 16'h0000, N, N});
    tbl.push_back(vec_t'{Y, 16'h003E, Y, 32'h100, N, N, N, Y, MF, TV, 32'h7C, Y, N, 32'h0000_0003, 32'h78, N, 32'h0, 16'h0, Y, N});
    tbl.push_back(vec_t'{Y, 16'h003E, N, 32'h00, N, N, N, N, MF, TV, 32'h7C, N, N, 32'h0000_0003, 32'h78, Y, 32'h7C, 16'h0, N, N});

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) runVec(tbl[i]);

    // Reset during the TRAP cycle: no trap/redirect afterwards, pending cleared.
    runVec(vec_t'{Y, 16'h0000, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, N, 32'h0000_0003, 32'h78, N, 32'h0, 16'h0, N, N});
    runVec(vec_t'{Y, 16'h0008, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, N, 32'h0000_0003, 32'h78, N, 32'h0, 16'h0, N, N});
    runVec(vec_t'{Y, 16'h0008, Y, 32'h90, N, N, N, N, MF, T0, 32'h00, Y, N, 32'h0000_0003, 32'h78, N, 32'h0, 16'h0, N, N});
    runVec(vec_t'{N, 16'h0008, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, Y, 32'h8000_0013, 32'h90, Y, 32'h100, 16'h0008, N, N});
    runVec(vec_t'{Y, 16'h0000, Y, 32'h94, N, N, N, N, MF, T0, 32'h00, N, N, 32'h0, 32'h00, N, 32'h0, 16'h0, N, N});
    runVec(vec_t'{Y, 16'h0000, Y, 32'h98, N, N, N, N, MF, T0, 32'h00, N, N, 32'h0, 32'h00, N, 32'h0, 16'h0, N, N});

    // ECALL inside the handler locks up until reset; interrupts are ignored there.
    runVec(vec_t'{Y, 16'h0000, Y, 32'hA0, N, N, Y, N, MF, T0, 32'h00, Y, N, 32'h0, 32'h00, N, 32'h0, 16'h0, N, N});
    runVec(vec_t'{Y, 16'h0000, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, Y, 32'h0000_000B, 32'hA0, Y, 32'h100, 16'h0, N, N});
    runVec(vec_t'{Y, 16'h0000, Y, 32'h100, N, N, Y, N, MF, T0, 32'h00, Y, N, 32'h0000_000B, 32'hA0, N, 32'h0, 16'h0, Y, N});
    runVec(vec_t'{Y, 16'h0000, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, N, 32'h0000_000B, 32'hA0, N, 32'h0, 16'h0, N, Y});
    runVec(vec_t'{Y, 16'h0000, Y, 32'h104, N, N, N, Y, MF, T0, 32'h00, Y, N, 32'h0000_000B, 32'hA0, N, 32'h0, 16'h0, N, Y});
    runVec(vec_t'{Y, 16'h0008, Y, 32'h108, N, N, N, N, MF, T0, 32'h00, Y, N, 32'h0000_000B, 32'hA0, N, 32'h0, 16'h0, N, Y});
    runVec(vec_t'{Y, 16'h0008, Y, 32'h10C, N, N, N, N, MF, T0, 32'h00, Y, N, 32'h0000_000B, 32'hA0, N, 32'h0, 16'h0, N, Y});
    runVec(vec_t'{N, 16'h0008, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, N, 32'h0000_000B, 32'hA0, N, 32'h0, 16'h0, N, Y});
    runVec(vec_t'{Y, 16'h0000, N, 32'h00, N, N, N, N, MF, T0, 32'h00, N, N, 32'h0, 32'h00, N, 32'h0, 16'h0, N, N});

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
